// File: rtl/cpu_trace_buffer_if.sv
// Bundle of the trace buffer's control, capture and readout signals.
// master = debug controller side, slave = trace buffer side.
interface cpu_trace_buffer_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              arm;
    logic              mode;
    logic [AW-1:0]     post_cnt;
    logic [W-1:0]      trig_val;
    logic [W-1:0]      trig_mask;
    logic              smp_en;
    logic [CH*W-1:0]   smp_data;
    logic              rd_en;
    logic [CH*W-1:0]   rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic [AW:0]       level;
    logic              busy;
    logic              done;
    logic              trig_hit;

    modport master (
        output arm, mode, post_cnt, trig_val, trig_mask, smp_en, smp_data, rd_en,
        input  rd_data, rd_valid, rd_empty, level, busy, done, trig_hit
    );

    modport slave (
        input  arm, mode, post_cnt, trig_val, trig_mask, smp_en, smp_data, rd_en,
        output rd_data, rd_valid, rd_empty, level, busy, done, trig_hit
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of CH x W-bit samples with masked trigger, post-trigger
// count or fill-once mode, and destructive oldest-first readout.
module cpu_trace_buffer #(
    parameter int unsigned W     = 32,
    parameter int unsigned CH    = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    cpu_trace_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LvlFull = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [AW-1:0]     remaining_q, remaining_d;
    logic [AW-1:0]     post_cnt_q, post_cnt_d;
    logic              mode_q, mode_d;
    logic              trig_hit_q, trig_hit_d;
    logic [CH*W-1:0]   rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_empty_q, rd_empty_d;
    logic              mem_we;
    logic              trig_match;
    logic [CH*W-1:0]   mem [DEPTH];

    assign trig_match = ((bus.smp_data[W-1:0] ^ bus.trig_val) & bus.trig_mask) == '0;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        remaining_d = remaining_q;
        post_cnt_d  = post_cnt_q;
        mode_d      = mode_q;
        trig_hit_d  = trig_hit_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        mem_we      = 1'b0;

        if (bus.arm) begin
            wr_ptr_d    = '0;
            level_d     = '0;
            trig_hit_d  = 1'b0;
            mode_d      = bus.mode;
            post_cnt_d  = bus.post_cnt;
            remaining_d = '0;
            state_d     = StArmed;
        end else begin
            case (state_q)
                StArmed, StPost: begin
                    if (bus.smp_en) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // Once full, level saturates and the oldest entry is overwritten.
                        if (level_q != LvlFull) level_d = level_q + 1'b1;
                        if (state_q == StArmed) begin
                            if (!mode_q && trig_match) begin
                                trig_hit_d = 1'b1;
                                if (post_cnt_q == '0) begin
                                    state_d = StDone;
                                end else begin
                                    state_d     = StPost;
                                    remaining_d = post_cnt_q;
                                end
                            end else if (mode_q && level_d == LvlFull) begin
                                state_d = StDone;
                            end
                        end else begin
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_d == '0) state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.rd_en && level_q != '0) begin
                        rd_data_d  = mem[rd_ptr_q];
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        level_d    = level_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Point the reader at the oldest surviving entry; a full level wraps to wr_ptr.
        if (state_q != StDone && state_d == StDone) begin
            rd_ptr_d = wr_ptr_d - level_d[AW-1:0];
        end

        busy_d     = (state_d == StArmed) || (state_d == StPost);
        done_d     = (state_d == StDone);
        rd_empty_d = ((state_d == StIdle) || (state_d == StDone)) && (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            remaining_q <= '0;
            post_cnt_q  <= '0;
            mode_q      <= 1'b0;
            trig_hit_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_empty_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            remaining_q <= remaining_d;
            post_cnt_q  <= post_cnt_d;
            mode_q      <= mode_d;
            trig_hit_q  <= trig_hit_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_empty_q  <= rd_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[wr_ptr_q] <= bus.smp_data;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_empty = rd_empty_q;
    assign bus.level    = level_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.trig_hit = trig_hit_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus random traffic, checked
// against a queue-based reference model of the capture window.
module tb_cpu_trace_buffer;
    localparam int unsigned W     = 32;
    localparam int unsigned CH    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned DW    = CH * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.W(W), .CH(CH), .DEPTH(DEPTH)) bus ();

    cpu_trace_buffer #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 armed, 2 post, 3 done; window kept as a queue.
    int            m_state = 0;
    logic [DW-1:0] m_q[$];
    logic          m_mode = 1'b0;
    int            m_post = 0;
    int            m_rem = 0;
    logic          m_hit = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [W-1:0] c0);
        return {$urandom, $urandom, $urandom, c0};
    endfunction

    task automatic model_step();
        logic [DW-1:0] din = bus.smp_data;
        logic          mt  = ((din[W-1:0] ^ bus.trig_val) & bus.trig_mask) == '0;
        if (rst) begin
            m_state = 0; m_q.delete(); m_hit = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
        end else if (bus.arm) begin
            m_q.delete(); m_hit = 1'b0; m_mode = bus.mode; m_post = int'(bus.post_cnt);
            m_state = 1; m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = 1'b0;
            if ((m_state == 1 || m_state == 2) && bus.smp_en) begin
                m_q.push_back(din);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
                if (m_state == 1) begin
                    if (!m_mode && mt) begin
                        m_hit = 1'b1;
                        if (m_post == 0) m_state = 3;
                        else begin m_state = 2; m_rem = m_post; end
                    end else if (m_mode && m_q.size() == DEPTH) begin
                        m_state = 3;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
            end else if (m_state == 3 && bus.rd_en && m_q.size() > 0) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("level",    DW'(bus.level),    DW'(m_q.size()));
        check("busy",     DW'(bus.busy),     DW'(m_state == 1 || m_state == 2));
        check("done",     DW'(bus.done),     DW'(m_state == 3));
        check("trig_hit", DW'(bus.trig_hit), DW'(m_hit));
        check("rd_valid", DW'(bus.rd_valid), DW'(m_rd_valid));
        check("rd_empty", DW'(bus.rd_empty),
              DW'((m_state == 0 || m_state == 3) && m_q.size() == 0));
        check("rd_data",  bus.rd_data,       m_rd_data);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        bus.arm = 1'b0; bus.smp_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic do_arm(input logic md, input logic [AW-1:0] pc,
                          input logic [W-1:0] tv, input logic [W-1:0] tm);
        bus.arm = 1'b1; bus.mode = md; bus.post_cnt = pc;
        bus.trig_val = tv; bus.trig_mask = tm;
        bus.smp_en = 1'b1; bus.smp_data = mk(tv);  // must not be written
        cycle();
        quiet();
        check("arm_level", DW'(bus.level), '0);
        check("arm_busy",  DW'(bus.busy),  DW'(1));
    endtask

    initial begin
        int nv;
        rst = 1'b1;
        quiet();
        bus.mode = 1'b0; bus.post_cnt = '0; bus.trig_val = '0; bus.trig_mask = '0;
        bus.smp_data = '0;
        cycle(); cycle();
        check("rst_empty", DW'(bus.rd_empty), DW'(1));
        rst = 1'b0;

        // No arm: sampling is ignored.
        bus.smp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin bus.smp_data = mk($urandom); cycle(); end
        quiet();
        check("noarm_level", DW'(bus.level), '0);

        // Trigger at 0x24 with post_cnt=2.
        do_arm(1'b0, 3'd2, 32'h24, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) begin
            bus.smp_en = 1'b1; bus.smp_data = mk(32'(4 * i));
            cycle();
            if (i == 10) check("trig_done_early", DW'(bus.done), '0);
            if (i == 11) check("trig_done", DW'(bus.done), DW'(1));
        end
        quiet();
        check("trig_hit_set", DW'(bus.trig_hit), DW'(1));
        bus.rd_en = 1'b1; nv = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.rd_valid) begin
                check("trig_rd_ch0", DW'(bus.rd_data[W-1:0]), DW'(32'h10 + 32'(4 * nv)));
                nv++;
            end
        end
        quiet();
        check("trig_rd_pulses", DW'(nv), DW'(8));
        check("trig_rd_empty", DW'(bus.rd_empty), DW'(1));

        // Fill-once, samples on alternate cycles.
        do_arm(1'b1, 3'd0, 32'h0, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            bus.smp_en = 1'b1; bus.smp_data = mk(32'(k)); cycle();
            if (k == 8) begin
                check("fill_done", DW'(bus.done), DW'(1));
                check("fill_level", DW'(bus.level), DW'(8));
                check("fill_nohit", DW'(bus.trig_hit), '0);
            end
            bus.smp_en = 1'b0; cycle();
        end
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("fill_rd_ch0", DW'(bus.rd_data[W-1:0]), DW'(k));
        end
        quiet(); cycle();

        // Masked trigger, post_cnt=0.
        do_arm(1'b0, 3'd0, 32'h100, 32'hFFFF_FF00);
        bus.smp_en = 1'b1;
        bus.smp_data = mk(32'hF0); cycle();
        bus.smp_data = mk(32'hF8); cycle();
        check("mask_not_done", DW'(bus.done), '0);
        bus.smp_data = mk(32'h104); cycle();
        quiet();
        check("mask_done", DW'(bus.done), DW'(1));
        check("mask_level", DW'(bus.level), DW'(3));
        bus.rd_en = 1'b1; cycle(); cycle(); cycle();
        check("mask_last", DW'(bus.rd_data[W-1:0]), DW'(32'h104));
        quiet();

        // arm together with rd_en in DONE: arm wins.
        do_arm(1'b0, 3'd0, 32'h0, 32'h0);
        bus.smp_en = 1'b1; bus.smp_data = mk(32'h5); cycle(); quiet();
        check("ar_done", DW'(bus.done), DW'(1));
        bus.rd_en = 1'b1;
        do_arm(1'b0, 3'd0, 32'h0, 32'h0);
        check("ar_no_read", DW'(bus.rd_valid), '0);

        // Re-arm mid-POST.
        do_arm(1'b0, 3'd5, 32'h0, 32'h0);
        bus.smp_en = 1'b1; bus.smp_data = mk(32'h1); cycle(); cycle(); quiet();
        check("post_hit", DW'(bus.trig_hit), DW'(1));
        do_arm(1'b0, 3'd3, 32'h0, 32'h0);
        check("rearm_hit", DW'(bus.trig_hit), '0);

        // Reset mid-readout.
        bus.smp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin bus.smp_data = mk(32'(i)); cycle(); end
        quiet(); bus.rd_en = 1'b1; cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0; quiet();
        check("rst_level", DW'(bus.level), '0);
        check("rst_data", bus.rd_data, '0);
        check("rst_done", DW'(bus.done), '0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            bus.arm    = ($urandom_range(0, 29) == 0);
            bus.mode   = $urandom_range(0, 3) == 0;
            bus.post_cnt = AW'($urandom_range(0, DEPTH - 1));
            if (bus.arm) begin
                bus.trig_val  = 32'($urandom_range(0, 15));
                bus.trig_mask = $urandom | 32'hFFFF_FFF0;
            end
            bus.smp_en   = $urandom_range(0, 1) == 1;
            bus.smp_data = mk(32'($urandom_range(0, 15)));
            bus.rd_en    = $urandom_range(0, 1) == 1;
            cycle();
        end
        rst = 1'b0; quiet();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
